// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//
// Purpose:
//   Two-master (inst, data) to one-slave arbiter for the SRAM-like request
//   interface. One request is selected per cycle and held stable until the
//   downstream accepts it. An owner FIFO remembers which master issued each
//   outstanding transaction, so in-order responses go back to the right
//   master. Data requests win by default. A starvation counter forces an
//   inst grant after STARVE_LIMIT consecutive data grants while inst waits.
//
// Ports:
//   i_clk, i_resetn                 clock, asynchronous active-low reset
//   i_inst_* / i_data_*             upstream requests (req, wr, size, wstrb,
//                                   addr, wdata)
//   o_inst_addr_ok / o_data_addr_ok request accepted this cycle
//   o_inst_data_ok / o_data_data_ok response for that master's oldest
//                                   outstanding transaction
//   o_inst_rdata / o_data_rdata     read data, valid with *_data_ok
//   o_m_*                           downstream request fields
//   i_m_addr_ok, i_m_data_ok        downstream accept and in-order response
//   i_m_rdata                       downstream read data
//   o_err_unexp                     sticky: response arrived with nothing
//                                   outstanding
module sram_req_arbiter #(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        i_clk,
  input  logic        i_resetn,

  input  logic        i_inst_req,
  input  logic        i_inst_wr,
  input  logic [1:0]  i_inst_size,
  input  logic [3:0]  i_inst_wstrb,
  input  logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_wdata,
  output logic        o_inst_addr_ok,
  output logic        o_inst_data_ok,
  output logic [31:0] o_inst_rdata,

  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [1:0]  i_data_size,
  input  logic [3:0]  i_data_wstrb,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_addr_ok,
  output logic        o_data_data_ok,
  output logic [31:0] o_data_rdata,

  output logic        o_m_req,
  output logic        o_m_wr,
  output logic [1:0]  o_m_size,
  output logic [3:0]  o_m_wstrb,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  input  logic        i_m_addr_ok,
  input  logic        i_m_data_ok,
  input  logic [31:0] i_m_rdata,

  output logic        o_err_unexp
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = PW + 1;
  localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_FULL   = CW'(MAX_OUT);

  typedef enum logic {
    SEL_INST = 1'b0,
    SEL_DATA = 1'b1
  } sel_e;

  logic [MAX_OUT-1:0] r_owner;
  logic [PW-1:0]      r_wrPtr;
  logic [PW-1:0]      r_rdPtr;
  logic [CW-1:0]      r_cnt;
  logic               r_lockV;
  sel_e               r_lockSel;
  logic [3:0]         r_starve;
  logic               r_errUnexp;

  logic w_selValid;
  sel_e w_sel;
  logic w_selReq;
  logic w_notFull;
  logic w_accept;
  logic w_pop;
  logic w_headOwner;

  // Pick the master. A pending (locked) request keeps its master so the
  // downstream never sees the request change underneath it; otherwise a
  // starved inst wins, then data, then inst.
  always_comb begin
    w_selValid = 1'b0;
    w_sel      = SEL_INST;
    if (r_lockV) begin
      w_selValid = 1'b1;
      w_sel      = r_lockSel;
    end else if ((r_starve == STARVE_MAX) && i_inst_req) begin
      w_selValid = 1'b1;
      w_sel      = SEL_INST;
    end else if (i_data_req) begin
      w_selValid = 1'b1;
      w_sel      = SEL_DATA;
    end else if (i_inst_req) begin
      w_selValid = 1'b1;
      w_sel      = SEL_INST;
    end
  end

  assign w_selReq  = w_selValid && ((w_sel == SEL_DATA) ? i_data_req : i_inst_req);
  assign w_notFull = (r_cnt < CNT_FULL);
  assign o_m_req   = w_selReq && w_notFull;
  assign w_accept  = o_m_req && i_m_addr_ok;

  // Downstream request fields follow the selected master, zero when idle.
  always_comb begin
    o_m_wr    = 1'b0;
    o_m_size  = 2'd0;
    o_m_wstrb = 4'd0;
    o_m_addr  = 32'd0;
    o_m_wdata = 32'd0;
    if (w_selValid) begin
      if (w_sel == SEL_DATA) begin
        o_m_wr    = i_data_wr;
        o_m_size  = i_data_size;
        o_m_wstrb = i_data_wstrb;
        o_m_addr  = i_data_addr;
        o_m_wdata = i_data_wdata;
      end else begin
        o_m_wr    = i_inst_wr;
        o_m_size  = i_inst_size;
        o_m_wstrb = i_inst_wstrb;
        o_m_addr  = i_inst_addr;
        o_m_wdata = i_inst_wdata;
      end
    end
  end

  assign o_inst_addr_ok = w_accept && (w_sel == SEL_INST);
  assign o_data_addr_ok = w_accept && (w_sel == SEL_DATA);

  // A response with nothing outstanding is not routed anywhere; it only
  // raises the sticky error flag.
  assign w_pop          = i_m_data_ok && (r_cnt != '0);
  assign w_headOwner    = r_owner[r_rdPtr];
  assign o_inst_data_ok = w_pop && !w_headOwner;
  assign o_data_data_ok = w_pop && w_headOwner;
  assign o_inst_rdata   = i_m_rdata;
  assign o_data_rdata   = i_m_rdata;
  assign o_err_unexp    = r_errUnexp;

  // Owner FIFO. Accept is already gated by not-full, so a push never
  // overwrites a live entry; a simultaneous push and pop leaves cnt alone.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_owner <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_owner[r_wrPtr] <= (w_sel == SEL_DATA);
        r_wrPtr          <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Lock holds the selection while the downstream stalls the request.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_lockV   <= 1'b0;
      r_lockSel <= SEL_INST;
    end else if (w_accept) begin
      r_lockV <= 1'b0;
    end else if (o_m_req) begin
      r_lockV   <= 1'b1;
      r_lockSel <= w_sel;
    end
  end

  // Counts data grants taken while inst is waiting; saturates at the limit,
  // which is what forces the next inst grant.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_starve <= 4'd0;
    end else if (w_accept && (w_sel == SEL_DATA) && i_inst_req) begin
      if (r_starve != STARVE_MAX) begin
        r_starve <= r_starve + 4'd1;
      end
    end else if (!i_inst_req || (w_accept && (w_sel == SEL_INST))) begin
      r_starve <= 4'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_errUnexp <= 1'b0;
    end else if (i_m_data_ok && (r_cnt == '0)) begin
      r_errUnexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter
//
// Purpose:
//   Directed self-checking bench for sram_req_arbiter (MAX_OUT=4,
//   STARVE_LIMIT=3). Expected values are hand-computed constants and
//   small tables of the intended grant/owner order.
//
// Ports: none (top-level bench).
module tb_sram_req_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        err_unexp;

  int checkCount;
  int errorCount;

  sram_req_arbiter #(.MAX_OUT(4), .STARVE_LIMIT(3)) dut (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_inst_req     (inst_req),
    .i_inst_wr      (inst_wr),
    .i_inst_size    (inst_size),
    .i_inst_wstrb   (inst_wstrb),
    .i_inst_addr    (inst_addr),
    .i_inst_wdata   (inst_wdata),
    .o_inst_addr_ok (inst_addr_ok),
    .o_inst_data_ok (inst_data_ok),
    .o_inst_rdata   (inst_rdata),
    .i_data_req     (data_req),
    .i_data_wr      (data_wr),
    .i_data_size    (data_size),
    .i_data_wstrb   (data_wstrb),
    .i_data_addr    (data_addr),
    .i_data_wdata   (data_wdata),
    .o_data_addr_ok (data_addr_ok),
    .o_data_data_ok (data_data_ok),
    .o_data_rdata   (data_rdata),
    .o_m_req        (m_req),
    .o_m_wr         (m_wr),
    .o_m_size       (m_size),
    .o_m_wstrb      (m_wstrb),
    .o_m_addr       (m_addr),
    .o_m_wdata      (m_wdata),
    .i_m_addr_ok    (m_addr_ok),
    .i_m_data_ok    (m_data_ok),
    .i_m_rdata      (m_rdata),
    .o_err_unexp    (err_unexp)
  );

  // 10-time-unit clock, rising edge active.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the control inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic iReq, input logic dReq, input logic addrOk,
                               input logic dataOk, input logic [31:0] rdata);
    inst_req  = iReq;
    data_req  = dReq;
    m_addr_ok = addrOk;
    m_data_ok = dataOk;
    m_rdata   = rdata;
    #2;
  endtask

  // Advance past the next rising edge; sampling happens 1 unit after it.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  logic grantSeq [8];
  logic ownerSeq [8];

  initial begin
    checkCount = 0;
    errorCount = 0;
    resetn     = 1'b0;
    inst_wr    = 1'b0;
    inst_size  = 2'd2;
    inst_wstrb = 4'h0;
    inst_addr  = 32'h1000_0000;
    inst_wdata = 32'h0;
    data_wr    = 1'b1;
    data_size  = 2'd1;
    data_wstrb = 4'b0011;
    data_addr  = 32'h2000_0040;
    data_wdata = 32'hCAFE_BABE;
    grantSeq   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ownerSeq   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] reset state");
    checkOutput("rst_m_req", 32'(m_req), 32'd0);
    checkOutput("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
    checkOutput("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    checkOutput("rst_err", 32'(err_unexp), 32'd0);
    checkOutput("rst_cnt", 32'(dut.r_cnt), 32'd0);
    nextCycle();
    resetn = 1'b1;
    nextCycle();

    $display("[TB] priority");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("pri_m_req", 32'(m_req), 32'd1);
    checkOutput("pri_data_addr_ok", 32'(data_addr_ok), 32'd1);
    checkOutput("pri_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    checkOutput("pri_m_addr", m_addr, 32'h2000_0040);
    checkOutput("pri_m_wr", 32'(m_wr), 32'd1);
    checkOutput("pri_m_size", 32'(m_size), 32'd1);
    checkOutput("pri_m_wstrb", 32'(m_wstrb), 32'h3);
    checkOutput("pri_m_wdata", m_wdata, 32'hCAFE_BABE);
    nextCycle();
    checkOutput("pri_cnt", 32'(dut.r_cnt), 32'd1);
    checkOutput("pri_starve", 32'(dut.r_starve), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001);
    checkOutput("pri_resp_data_ok", 32'(data_data_ok), 32'd1);
    checkOutput("pri_resp_inst_ok", 32'(inst_data_ok), 32'd0);
    checkOutput("pri_resp_rdata", data_rdata, 32'hA5A5_0001);
    checkOutput("pri_idle_m_addr", m_addr, 32'd0);
    nextCycle();
    checkOutput("pri_cnt_drained", 32'(dut.r_cnt), 32'd0);
    checkOutput("pri_starve_clr", 32'(dut.r_starve), 32'd0);

    $display("[TB] lock");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_c0_m_req", 32'(m_req), 32'd1);
    checkOutput("lock_c0_m_addr", m_addr, 32'h1000_0000);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_c1_lockv", 32'(dut.r_lockV), 32'd1);
    checkOutput("lock_c1_m_addr", m_addr, 32'h1000_0000);
    checkOutput("lock_c1_data_addr_ok", 32'(data_addr_ok), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("lock_c2_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    checkOutput("lock_c2_data_addr_ok", 32'(data_addr_ok), 32'd0);
    nextCycle();
    checkOutput("lock_c3_lockv", 32'(dut.r_lockV), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("lock_c3_data_addr_ok", 32'(data_addr_ok), 32'd1);
    checkOutput("lock_c3_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    checkOutput("lock_c3_m_addr", m_addr, 32'h2000_0040);
    nextCycle();
    checkOutput("lock_cnt", 32'(dut.r_cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0101);
    checkOutput("lock_resp0_inst_ok", 32'(inst_data_ok), 32'd1);
    checkOutput("lock_resp0_inst_rdata", inst_rdata, 32'h0000_0101);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0202);
    checkOutput("lock_resp1_data_ok", 32'(data_data_ok), 32'd1);
    checkOutput("lock_resp1_inst_ok", 32'(inst_data_ok), 32'd0);
    nextCycle();

    $display("[TB] starvation");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, (i > 0), 32'h0);
      checkOutput($sformatf("starve_g%0d_data", i), 32'(data_addr_ok), 32'(grantSeq[i]));
      checkOutput($sformatf("starve_g%0d_inst", i), 32'(inst_addr_ok), 32'(!grantSeq[i]));
      if (i > 0) begin
        checkOutput($sformatf("starve_r%0d_data_ok", i), 32'(data_data_ok),
                    32'(grantSeq[i-1]));
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("starve_last_inst_ok", 32'(inst_data_ok), 32'd1);
    nextCycle();
    checkOutput("starve_cnt", 32'(dut.r_cnt), 32'd0);

    $display("[TB] full");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("full_acc%0d", i), 32'(data_addr_ok), 32'd1);
      nextCycle();
    end
    checkOutput("full_cnt4", 32'(dut.r_cnt), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("full_m_req", 32'(m_req), 32'd0);
    checkOutput("full_data_addr_ok", 32'(data_addr_ok), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0077);
    checkOutput("full_pop_data_ok", 32'(data_data_ok), 32'd1);
    checkOutput("full_pop_m_req", 32'(m_req), 32'd0);
    nextCycle();
    checkOutput("full_cnt3", 32'(dut.r_cnt), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("full_reassert_m_req", 32'(m_req), 32'd1);
    checkOutput("full_reassert_ok", 32'(data_addr_ok), 32'd1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput($sformatf("full_drain%0d", i), 32'(data_data_ok), 32'd1);
      nextCycle();
    end
    checkOutput("full_cnt0", 32'(dut.r_cnt), 32'd0);

    $display("[TB] routing and wrap");
    for (int t = 0; t < 8; t++) begin
      logic issue;
      logic pop;
      logic [31:0] value;
      issue = (t < 6);
      pop   = (t >= 2);
      value = pop ? 32'h1111_1111 * 32'(t - 1) : 32'h0;
      applyStimulus(issue && !ownerSeq[t], issue && ownerSeq[t], issue, pop, value);
      if (issue) begin
        checkOutput($sformatf("route_acc%0d_inst", t), 32'(inst_addr_ok), 32'(!ownerSeq[t]));
        checkOutput($sformatf("route_acc%0d_data", t), 32'(data_addr_ok), 32'(ownerSeq[t]));
      end
      if (pop) begin
        checkOutput($sformatf("route_rsp%0d_inst", t - 2), 32'(inst_data_ok),
                    32'(!ownerSeq[t-2]));
        checkOutput($sformatf("route_rsp%0d_data", t - 2), 32'(data_data_ok),
                    32'(ownerSeq[t-2]));
        checkOutput($sformatf("route_rsp%0d_rdata", t - 2),
                    ownerSeq[t-2] ? data_rdata : inst_rdata, value);
      end
      nextCycle();
    end
    checkOutput("route_cnt", 32'(dut.r_cnt), 32'd0);

    $display("[TB] unexpected response");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h9999_9999);
    checkOutput("err_inst_data_ok", 32'(inst_data_ok), 32'd0);
    checkOutput("err_data_data_ok", 32'(data_data_ok), 32'd0);
    nextCycle();
    checkOutput("err_set", 32'(err_unexp), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("err_sticky", 32'(err_unexp), 32'd1);

    $display("[TB] reset mid-transfer");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_cnt2", 32'(dut.r_cnt), 32'd2);
    checkOutput("mid_lockv1", 32'(dut.r_lockV), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_cnt", 32'(dut.r_cnt), 32'd0);
    checkOutput("mid_rst_err", 32'(err_unexp), 32'd0);
    checkOutput("mid_rst_lockv", 32'(dut.r_lockV), 32'd0);
    checkOutput("mid_rst_m_req", 32'(m_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    resetn = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("post_rst_no_data_ok", 32'(inst_data_ok | data_data_ok), 32'd0);
    nextCycle();
    checkOutput("post_rst_err", 32'(err_unexp), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
